// File: rtl/seven_segment_seconds.sv
// seven_segment_seconds
//   Counts clock cycles and advances a decimal digit 0..9 (wrapping) every
//   P cycles, where P is a reset-default or runtime-loaded compare value
//   (compare == 0 behaves as P = 1). The digit drives a common-cathode
//   7-segment display on user GPIO pads.
//
// Ports
//   clock          in   block clock, all state on rising edge
//   resetb         in   asynchronous active-low reset
//   compare_in     in   new tick period in clock cycles
//   update_compare in   single-cycle strobe, loads compare_in and clears counter
//   segments       out  {g,f,e,d,c,b,a}, 1 = lit; decoded from registered digit
//   io_oeb         out  pad output enables, active low, always driving
//   digit          out  current digit 0..9 (debug)
module seven_segment_seconds #(
    parameter int unsigned          COMPARE_W       = 24,
    parameter logic [COMPARE_W-1:0] DEFAULT_COMPARE = COMPARE_W'(1000)
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic [COMPARE_W-1:0] compare_in,
    input  logic                 update_compare,
    output logic [6:0]           segments,
    output logic [6:0]           io_oeb,
    output logic [3:0]           digit
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    logic [COMPARE_W-1:0] count_q;
    logic [COMPARE_W-1:0] compare_q;
    logic [DIGIT_W-1:0]   digit_q;
    logic [COMPARE_W-1:0] last_count;
    logic                 tick;
    logic [DIGIT_W-1:0]   digit_next;

    // Terminal count is P-1; a zero compare collapses to P = 1 (tick every edge).
    always_comb begin
        last_count = '0;
        if (compare_q != '0) begin
            last_count = compare_q - COMPARE_W'(1);
        end
        tick = (count_q == last_count);
    end

    // Out-of-range digit codes recover to 0 on the next tick.
    always_comb begin
        digit_next = digit_q + DIGIT_W'(1);
        if (digit_q >= DIGIT_W'(9)) begin
            digit_next = '0;
        end
    end

    // Period counter, compare register and digit; a compare load wins over a tick.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            count_q   <= '0;
            compare_q <= DEFAULT_COMPARE;
            digit_q   <= '0;
        end else if (update_compare) begin
            compare_q <= compare_in;
            count_q   <= '0;
        end else if (tick) begin
            count_q <= '0;
            digit_q <= digit_next;
        end else begin
            count_q <= count_q + COMPARE_W'(1);
        end
    end

    // Segment decode of the registered digit, bit order g..a.
    always_comb begin
        segments = '0;
        unique case (digit_q)
            4'd0:    segments = SEG_W'(7'b0111111);
            4'd1:    segments = SEG_W'(7'b0000110);
            4'd2:    segments = SEG_W'(7'b1011011);
            4'd3:    segments = SEG_W'(7'b1001111);
            4'd4:    segments = SEG_W'(7'b1100110);
            4'd5:    segments = SEG_W'(7'b1101101);
            4'd6:    segments = SEG_W'(7'b1111100);
            4'd7:    segments = SEG_W'(7'b0000111);
            4'd8:    segments = SEG_W'(7'b1111111);
            4'd9:    segments = SEG_W'(7'b1100111);
            default: segments = '0;
        endcase
    end

    assign io_oeb = '0;
    assign digit  = digit_q;

endmodule

// File: tb/tb_seven_segment_seconds.sv
// Scoreboard bench for seven_segment_seconds: the stimulus process predicts
// every digit change (edge number and value) from a period/anchor model and
// queues it; a negedge monitor pops and compares whenever the digit moves.
module tb_seven_segment_seconds;

    localparam int unsigned CW  = 24;
    localparam int          DEF = 1000;

    logic          clock          = 1'b0;
    logic          resetb         = 1'b0;
    logic [CW-1:0] compare_in     = '0;
    logic          update_compare = 1'b0;
    logic [6:0]    segments;
    logic [6:0]    io_oeb;
    logic [3:0]    digit;

    seven_segment_seconds dut (
        .clock          (clock),
        .resetb         (resetb),
        .compare_in     (compare_in),
        .update_compare (update_compare),
        .segments       (segments),
        .io_oeb         (io_oeb),
        .digit          (digit)
    );

    always #5 clock = ~clock;

    logic [6:0] seg_tbl [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111100, 7'b0000111,
                                  7'b1111111, 7'b1100111};

    int errors = 0;
    int checks = 0;

    typedef struct {
        int e;
        int d;
    } exp_t;
    exp_t sb[$];

    // Model state: digit = (base + (edge - anchor) / per) mod 10 for edges after anchor.
    int edge_n = 0;
    int anchor = 0;
    int base   = 0;
    int per    = DEF;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    function automatic int model_digit(input int e);
        return (base + (e - anchor) / per) % 10;
    endfunction

    // Advance one rising edge and update the model with the inputs sampled there.
    task automatic tick_edge();
        @(posedge clock);
        edge_n++;
        if (!resetb) begin
            anchor = edge_n;
            base   = 0;
            per    = DEF;
            sb.delete();
        end else if (update_compare) begin
            base   = model_digit(edge_n - 1);
            anchor = edge_n;
            per    = (compare_in == '0) ? 1 : int'(compare_in);
        end else if ((edge_n - anchor) % per == 0) begin
            sb.push_back('{edge_n, model_digit(edge_n)});
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_edge();
    endtask

    task automatic pulse(input int val);
        compare_in     = CW'(val);
        update_compare = 1'b1;
        tick_edge();
        update_compare = 1'b0;
        compare_in     = CW'($urandom);
    endtask

    // Monitor: every digit change must match the head of the scoreboard.
    logic [3:0] prev = '0;
    always @(negedge clock) begin
        if (!resetb) begin
            prev = '0;
        end else begin
            if (digit != prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_change", int'(digit), int'(prev));
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("change_edge", edge_n, x.e);
                    check("change_digit", int'(digit), x.d);
                    check("change_segments", int'(segments), int'(seg_tbl[x.d]));
                    check("io_oeb", int'(io_oeb), 0);
                end
            end else if (sb.size() > 0 && sb[0].e <= edge_n) begin
                exp_t x;
                x = sb.pop_front();
                check("missed_change", int'(digit), x.d);
            end
            prev = digit;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  hit;

        // Reset held for 80 cycles.
        resetb = 1'b0;
        run(80);
        check("reset_digit", int'(digit), 0);
        check("reset_segments", int'(segments), int'(7'b0111111));
        check("reset_io_oeb", int'(io_oeb), 0);

        // Release between edges; default period, full sequence plus wrap.
        resetb = 1'b1;
        run(11000);
        check("wrap_digit", int'(digit), 1);

        // Runtime compare loads.
        run(500);
        pulse(5);
        run(60);
        pulse(0);
        run(25);

        // Random compare loads at random gaps.
        for (int i = 0; i < 20; i++) begin
            run(int'($urandom_range(0, 30)));
            pulse(int'($urandom_range(0, 12)));
        end
        run(40);

        // Collision: load on the edge where the counter sits at P-1.
        pulse(7);
        n = 0;
        while (((edge_n + 1 - anchor) % per) != 0 && n < 100) begin
            tick_edge();
            n++;
        end
        pulse(4);
        run(20);

        // Async reset mid-run while digit is 7.
        pulse(3);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick_edge();
            if (digit == 4'd7) hit = 1'b1;
        end
        check("reached_seven", int'(hit), 1);
        @(negedge clock);
        #2;
        resetb = 1'b0;
        sb.delete();
        #1;
        check("async_digit", int'(digit), 0);
        check("async_segments", int'(segments), int'(7'b0111111));
        check("async_io_oeb", int'(io_oeb), 0);
        run(3);
        resetb = 1'b1;
        // Default period must be back: next change exactly DEF edges later.
        run(DEF + 10);
        check("post_reset_digit", int'(digit), 1);

        @(negedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_seconds.md
Name: seven_segment_seconds

Overview:
User-area block that counts clock cycles and advances a decimal digit 0→9 (wrapping to 0) each time a programmable tick period elapses. The digit drives a common-cathode 7-segment display on user GPIO pads [6:0]. It sits inside the user project wrapper, clocked by the Caravel user clock. The period is a reset default or a runtime-loaded compare value, so simulation can use short periods.

Parameters:
- COMPARE_W, 24, width of the tick-period counter and compare register.
- DEFAULT_COMPARE, 24'd1000, tick period in clock cycles loaded at reset (kept small for simulation; silicon builds override it, e.g. 10_000_000).

Ports:
- clock  in  1  single block clock; all state on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- compare_in  in  COMPARE_W  new tick period, in clock cycles.
- update_compare  in  1  single-cycle strobe; loads compare_in.
- segments  out  7  segment drive {g,f,e,d,c,b,a}; 1 = segment lit; mapped to mprj_io[6:0].
- io_oeb  out  7  pad output-enable, active low; constant 7'b0000000 (always driving).
- digit  out  4  current digit value 0..9, for debug and verification.

Behaviour:
- One clock; reset is asynchronous and active-low (resetb). All state registers clear on resetb low, with no clock edge required.
- Reset values:
  - tick counter = 0
  - compare = DEFAULT_COMPARE
  - digit = 0
  - segments = 7'b0111111 (shows "0")
  - io_oeb = 0
- Effective period P = compare, except that compare==0 is treated as 1.
- Each rising edge with update_compare=0:
  - if tick counter == P-1: counter <= 0; digit <= (digit==9) ? 0 : digit+1.
  - otherwise: counter <= counter+1.
- With update_compare=1 on an edge:
  - compare <= compare_in and counter <= 0; digit holds.
  - This load takes priority over a coincident tick, so the tick is dropped.
  - The new period timing starts from the next edge.
- Resulting timing after reset release: digit goes 0→1 exactly P rising edges later, then advances every P edges. After 9 comes 0, giving a sequence period of 10·P.
- If compare is loaded with a value ≤ the current counter value, the counter is cleared anyway, so no overflow wrap past 2^COMPARE_W occurs.
- segments is a combinational decode of the registered digit; it changes in the same cycle as digit and is glitch-free at the pads in RTL. Decode, bit order g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111100 (no a), 7=0000111, 8=1111111, 9=1100111 (no d)
- Digit codes 10..15 are unreachable. If they are ever forced, decode to 0000000 and the next tick goes to 0.
- Reset asserted mid-count: digit, counter and compare all return to their reset values immediately. A runtime-loaded compare is lost.

Test Plan:
- Reset: hold resetb=0 for 80 cycles → segments=0111111, digit=0, io_oeb=0. Release → first change at exactly DEFAULT_COMPARE (1000) edges.
- Full sequence, DEFAULT_COMPARE=1000 → segments go 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111100, 0000111, 1111111, 1100111 in order, each held 1000 cycles; all ten seen within 25000 cycles.
- Wrap: run 11 periods → after 1100111 ("9") segments return to 0111111 and digit=0.
- Runtime compare: at cycle 500 pulse update_compare with compare_in=5 → counter clears; digit steps every 5 cycles thereafter. With compare_in=0 → digit steps every cycle.
- Collision: pulse update_compare on the edge where counter==P-1 → digit does not advance on that edge; next step comes P_new edges later.
- Async reset mid-run: drop resetb between edges while digit=7 → segments=0111111 with no clock edge; compare is back at DEFAULT_COMPARE.
